// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared constants and BCD helpers for the stopwatch counter.
//               CS_MAX/SEC_MAX/MIN_MAX are the terminal values of each digit
//               pair. bcd_valid_60 checks a 00-59 BCD value. bcd_inc returns
//               {carry, next} for one increment with wrap at max.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  localparam logic [7:0] CS_MAX  = 8'h99;
  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;

  // True when both digits form a legal 00-59 BCD value.
  function automatic logic bcd_valid_60(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5);
  endfunction

  // One BCD increment of a digit pair. At max the pair wraps to 00 and the
  // returned carry bit (bit 8) is set.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [8:0] r;
    if (v == max)
      r = 9'h100;
    else if (v[3:0] == 4'd9)
      r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_counter_bcd_digit_pair.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_pair
// Description : Two-digit packed BCD counter wrapping at MAX.
//   clk      in  1  system clock
//   rst_n    in  1  asynchronous active-low reset
//   clr      in  1  synchronous clear to 00 (highest priority)
//   load     in  1  synchronous load of load_val
//   load_val in  8  value taken on load
//   inc      in  1  increment request
//   value    out 8  current BCD value
//   carry    out 1  inc while at MAX (value wraps to 00 on this edge)
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_pair
  import stopwatch_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry
);

  logic [8:0] w_next;

  assign w_next = bcd_inc(value, MAX);
  assign carry  = inc & w_next[8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      value <= 8'h00;
    else if (clr)
      value <= 8'h00;
    else if (load)
      value <= load_val;
    else if (inc)
      value <= w_next[7:0];
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_counter
// Description : Stopwatch time base. Divides clk to a 100 Hz tick and keeps
//               mm:ss.cc in packed BCD, with clear and edge-qualified preset.
//   clk        in  1  system clock
//   rst_n      in  1  asynchronous active-low reset
//   en         in  1  run (1) / hold (0)
//   clr        in  1  synchronous clear, overrides everything else
//   load       in  1  preset request level; its rising edge acts
//   preset_min in  8  BCD minutes preset
//   preset_sec in  8  BCD seconds preset
//   cs_bcd     out 8  centiseconds 00-99
//   sec_bcd    out 8  seconds 00-59
//   min_bcd    out 8  minutes 00-59
//   tick       out 1  pulse on each counted 1/100 s period
//   rollover   out 1  pulse on the tick that wraps 59:59.99 to 00:00.00
//   load_err   out 1  pulse when a load edge carries an invalid preset
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [7:0] cs_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic       tick,
  output logic       rollover,
  output logic       load_err
);

  // Derived from CLK_HZ only, so it cannot be overridden out of step.
  localparam int              TICK_DIV   = CLK_HZ / 100;
  localparam int              PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic          r_load_q;
  logic          w_load_edge;
  logic          w_preset_ok;
  logic          w_do_load;
  logic          w_inc;
  logic          w_cs_carry;
  logic          w_sec_carry;

  assign w_load_edge = load & ~r_load_q;
  assign w_preset_ok = bcd_valid_60(preset_min) & bcd_valid_60(preset_sec);
  assign w_do_load   = w_load_edge & ~clr & w_preset_ok;
  // An invalid preset only raises load_err; counting carries on untouched.
  assign load_err    = w_load_edge & ~clr & ~w_preset_ok;

  // Tick is still reported on a loading cycle, but the load takes the edge,
  // so the increment is dropped.
  assign tick  = en & ~clr & (r_presc == PRESC_LAST);
  assign w_inc = tick & ~w_do_load;

  // Edge register samples every cycle, so an edge under clr is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_load_q <= 1'b0;
    else
      r_load_q <= load;
  end

  // Holding en low freezes the partial period rather than restarting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_presc <= '0;
    else if (clr || w_do_load)
      r_presc <= '0;
    else if (en)
      r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
  end

  bcd_digit_pair #(.MAX(CS_MAX)) u_cs (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (w_do_load),
    .load_val (8'h00),
    .inc      (w_inc),
    .value    (cs_bcd),
    .carry    (w_cs_carry)
  );

  bcd_digit_pair #(.MAX(SEC_MAX)) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (w_do_load),
    .load_val (preset_sec),
    .inc      (w_cs_carry),
    .value    (sec_bcd),
    .carry    (w_sec_carry)
  );

  // Carry out of minutes is exactly the 59:59.99 -> 00:00.00 wrap.
  bcd_digit_pair #(.MAX(MIN_MAX)) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (w_do_load),
    .load_val (preset_min),
    .inc      (w_sec_carry),
    .value    (min_bcd),
    .carry    (rollover)
  );

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_counter
// Description : Self-checking bench for stopwatch_counter at CLK_HZ=1000.
//               A segment table drives the stimulus; an integer-arithmetic
//               reference model pushes per-cycle expectations to a queue that
//               is popped against the DUT. Segment totals are also checked.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_counter;

  localparam int CLK_HZ   = 1000;
  localparam int TICK_DIV = CLK_HZ / 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, clr, load;
  logic [7:0] preset_min, preset_sec;
  logic [7:0] cs_bcd, sec_bcd, min_bcd;
  logic       tick, rollover, load_err;

  always #5 clk = ~clk;

  stopwatch_counter #(.CLK_HZ(CLK_HZ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .load       (load),
    .preset_min (preset_min),
    .preset_sec (preset_sec),
    .cs_bcd     (cs_bcd),
    .sec_bcd    (sec_bcd),
    .min_bcd    (min_bcd),
    .tick       (tick),
    .rollover   (rollover),
    .load_err   (load_err)
  );

  typedef struct {
    logic       tick, rollover, load_err;
    logic [7:0] cs, sec, mn;
  } exp_t;

  typedef struct {
    logic       en, clr, load;
    logic [7:0] pm, ps;
    int         cycles;
    logic [7:0] mn, sec, cs;
    int         ticks, rolls, lerrs;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[16];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (plain integers, not BCD)
  int   m_min, m_sec, m_cs, m_presc;
  logic m_lq;

  int seg_ticks, seg_rolls, seg_lerrs;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic vec_t mk(input logic e, input logic c, input logic l,
                              input logic [7:0] pm, input logic [7:0] ps, input int n,
                              input logic [7:0] emn, input logic [7:0] esec, input logic [7:0] ecs,
                              input int t, input int r, input int le);
    vec_t v;
    v.en = e; v.clr = c; v.load = l; v.pm = pm; v.ps = ps; v.cycles = n;
    v.mn = emn; v.sec = esec; v.cs = ecs; v.ticks = t; v.rolls = r; v.lerrs = le;
    return v;
  endfunction

  task automatic check_v(input string name, input logic [23:0] act, input logic [23:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_i(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Advance the model one clock with the given inputs and queue the result.
  task automatic model_push(input logic e, input logic c, input logic l,
                            input logic [7:0] pm, input logic [7:0] ps);
    exp_t x;
    logic edge_seen, ok;
    int   total;
    edge_seen  = l && !m_lq;
    ok         = (pm[7:4] < 6) && (pm[3:0] < 10) && (ps[7:4] < 6) && (ps[3:0] < 10);
    x.tick     = e && !c && (m_presc == TICK_DIV - 1);
    x.rollover = 1'b0;
    x.load_err = 1'b0;
    if (c) begin
      m_min = 0; m_sec = 0; m_cs = 0; m_presc = 0;
    end else begin
      if (edge_seen && !ok) x.load_err = 1'b1;
      if (edge_seen && ok) begin
        m_min = from_bcd(pm); m_sec = from_bcd(ps); m_cs = 0; m_presc = 0;
      end else if (e) begin
        if (m_presc == TICK_DIV - 1) begin
          m_presc = 0;
          total = (m_min * 60 + m_sec) * 100 + m_cs + 1;
          if (total == 360000) begin
            x.rollover = 1'b1;
            total = 0;
          end
          m_cs  = total % 100;
          m_sec = (total / 100) % 60;
          m_min = total / 6000;
        end else begin
          m_presc = m_presc + 1;
        end
      end
    end
    m_lq  = l;
    x.cs  = to_bcd(m_cs);
    x.sec = to_bcd(m_sec);
    x.mn  = to_bcd(m_min);
    sb_q.push_back(x);
  endtask

  task automatic run_cycle(input logic e, input logic c, input logic l,
                           input logic [7:0] pm, input logic [7:0] ps);
    exp_t x;
    @(negedge clk);
    en = e; clr = c; load = l; preset_min = pm; preset_sec = ps;
    model_push(e, c, l, pm, ps);
    #1;
    x = sb_q[0];
    check_v("pulses", {21'd0, tick, rollover, load_err}, {21'd0, x.tick, x.rollover, x.load_err});
    seg_ticks += int'(tick);
    seg_rolls += int'(rollover);
    seg_lerrs += int'(load_err);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check_v("time", {min_bcd, sec_bcd, cs_bcd}, {x.mn, x.sec, x.cs});
  endtask

  initial begin
    //            en   clr  load pm     ps     cyc   min    sec    cs     tk  ro le
    vecs[0]  = mk(1'b1,1'b0,1'b0,8'h00,8'h00, 100, 8'h00,8'h00,8'h10, 10, 0, 0);
    vecs[1]  = mk(1'b1,1'b1,1'b0,8'h00,8'h00,   1, 8'h00,8'h00,8'h00,  0, 0, 0);
    vecs[2]  = mk(1'b1,1'b0,1'b0,8'h00,8'h00,   5, 8'h00,8'h00,8'h00,  0, 0, 0);
    vecs[3]  = mk(1'b0,1'b0,1'b0,8'h00,8'h00,  50, 8'h00,8'h00,8'h00,  0, 0, 0);
    vecs[4]  = mk(1'b1,1'b0,1'b0,8'h00,8'h00,   5, 8'h00,8'h00,8'h01,  1, 0, 0);
    vecs[5]  = mk(1'b1,1'b0,1'b1,8'h59,8'h59,   1, 8'h59,8'h59,8'h00,  0, 0, 0);
    vecs[6]  = mk(1'b1,1'b0,1'b0,8'h59,8'h59,1000, 8'h00,8'h00,8'h00,100, 1, 0);
    vecs[7]  = mk(1'b0,1'b0,1'b1,8'h00,8'h6A,   1, 8'h00,8'h00,8'h00,  0, 0, 1);
    vecs[8]  = mk(1'b0,1'b0,1'b1,8'h00,8'h6A,  20, 8'h00,8'h00,8'h00,  0, 0, 0);
    vecs[9]  = mk(1'b1,1'b0,1'b0,8'h00,8'h00,  23, 8'h00,8'h00,8'h02,  2, 0, 0);
    vecs[10] = mk(1'b1,1'b1,1'b1,8'h12,8'h34,   1, 8'h00,8'h00,8'h00,  0, 0, 0);
    vecs[11] = mk(1'b1,1'b0,1'b1,8'h12,8'h34,  10, 8'h00,8'h00,8'h01,  1, 0, 0);
    vecs[12] = mk(1'b1,1'b0,1'b0,8'h00,8'h00,   1, 8'h00,8'h00,8'h01,  0, 0, 0);
    vecs[13] = mk(1'b1,1'b0,1'b0,8'h00,8'h00,   8, 8'h00,8'h00,8'h01,  0, 0, 0);
    vecs[14] = mk(1'b1,1'b0,1'b1,8'h00,8'h03,   1, 8'h00,8'h03,8'h00,  1, 0, 0);
    vecs[15] = mk(1'b1,1'b0,1'b0,8'h00,8'h00, 470, 8'h00,8'h03,8'h47, 47, 0, 0);

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
    preset_min = 8'h00; preset_sec = 8'h00;
    m_min = 0; m_sec = 0; m_cs = 0; m_presc = 0; m_lq = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_v("reset_time", {min_bcd, sec_bcd, cs_bcd}, 24'h000000);
    check_v("reset_pulses", {21'd0, tick, rollover, load_err}, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      seg_ticks = 0; seg_rolls = 0; seg_lerrs = 0;
      for (int k = 0; k < vecs[i].cycles; k++)
        run_cycle(vecs[i].en, vecs[i].clr, vecs[i].load, vecs[i].pm, vecs[i].ps);
      check_v($sformatf("seg%0d_time", i), {min_bcd, sec_bcd, cs_bcd},
              {vecs[i].mn, vecs[i].sec, vecs[i].cs});
      check_i($sformatf("seg%0d_ticks", i), seg_ticks, vecs[i].ticks);
      check_i($sformatf("seg%0d_rollovers", i), seg_rolls, vecs[i].rolls);
      check_i($sformatf("seg%0d_load_errs", i), seg_lerrs, vecs[i].lerrs);
    end

    // Bring the prescaler to its last count at 00:03.47, then reset between
    // edges while a tick is being asserted.
    for (int k = 0; k < 9; k++)
      run_cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    #1;
    check_v("pre_reset_time", {min_bcd, sec_bcd, cs_bcd}, 24'h000347);
    check_i("pre_reset_tick", int'(tick), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_v("async_reset_time", {min_bcd, sec_bcd, cs_bcd}, 24'h000000);
    check_i("async_reset_tick", int'(tick), 0);
    check_i("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
